// File: rtl/sram_access_arbiter_pkg.sv
// Shared definitions for the SRAM access arbiter: default widths, FSM encodings and port ids.
package sram_access_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_TURN   = 2'd3;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PortA) ? PortB : PortA;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: picks one requester and hands priority to the loser.
module rr_arbiter2
    import sram_access_arbiter_pkg::*;
(
    input  logic  req_a_i,
    input  logic  req_b_i,
    input  port_e ptr_i,
    output logic  gnt_a_o,
    output logic  gnt_b_o,
    output port_e ptr_o
);

    always_comb begin
        gnt_a_o = req_a_i && (!req_b_i || (ptr_i == PortA));
        gnt_b_o = req_b_i && !gnt_a_o;
        ptr_o   = ptr_i;
        if (gnt_a_o) begin
            ptr_o = other_port(PortA);
        end else if (gnt_b_o) begin
            ptr_o = other_port(PortB);
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Sequences single-word async SRAM accesses for two requesters (record A, playback B).
// Every output is a register; the FSM computes next output values alongside the next state.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ce_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o,
    output logic              rw_o,
    output logic [DATA_W-1:0] dw_o,
    input  logic [DATA_W-1:0] dr_i
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    port_e            owner_q, owner_d, ptr_q, ptr_d, ptr_nxt;
    logic             we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dw_q, dw_d, rdata_q, rdata_d;
    logic             ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, rw_q, rw_d;
    logic             a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic             a_rv_q, a_rv_d, b_rv_q, b_rv_d;
    logic             win_a, win_b, sel_we;

    rr_arbiter2 u_rr (
        .req_a_i (a_req_i),
        .req_b_i (b_req_i),
        .ptr_i   (ptr_q),
        .gnt_a_o (win_a),
        .gnt_b_o (win_b),
        .ptr_o   (ptr_nxt)
    );

    assign sel_we = win_a ? a_we_i : b_we_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dw_d    = dw_q;
        rdata_d = rdata_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        rw_d    = rw_q;
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        a_rv_d  = 1'b0;
        b_rv_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_a || win_b) begin
                    state_d = ST_SETUP;
                    owner_d = win_a ? PortA : PortB;
                    ptr_d   = ptr_nxt;
                    we_d    = sel_we;
                    addr_d  = win_a ? a_addr_i : b_addr_i;
                    if (sel_we) begin
                        dw_d = win_a ? a_wdata_i : b_wdata_i;
                    end
                    ce_n_d  = 1'b0;
                    rw_d    = sel_we;
                    oe_n_d  = sel_we;
                    a_gnt_d = win_a;
                    b_gnt_d = win_b;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                we_n_d  = !we_q;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Release all strobes together so the separator can turn the bus around.
                    state_d = ST_TURN;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    rw_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = dr_i;
                        a_rv_d  = (owner_q == PortA);
                        b_rv_d  = (owner_q == PortB);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= PortA;
            ptr_q   <= PortA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dw_q    <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            rw_q    <= 1'b0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dw_q    <= dw_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            rw_q    <= rw_d;
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
        end
    end

    assign a_gnt_o    = a_gnt_q;
    assign b_gnt_o    = b_gnt_q;
    assign a_rvalid_o = a_rv_q;
    assign b_rvalid_o = b_rv_q;
    assign rdata_o    = rdata_q;
    assign mem_addr_o = addr_q;
    assign mem_ce_n_o = ce_n_q;
    assign mem_oe_n_o = oe_n_q;
    assign mem_we_n_o = we_n_q;
    assign rw_o       = rw_q;
    assign dw_o       = dw_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: transaction-timeline model for WAIT_CYCLES=2, plus
// strobe-width checks on WAIT_CYCLES=1 and 15 instances.
module tb_sram_access_arbiter;

    localparam int unsigned W = 2;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Main DUT signals
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [17:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wd = 0, b_wd = 0;
    logic        a_gnt, a_rv, b_gnt, b_rv, ce_n, oe_n, we_n, rw;
    logic [15:0] rdata, dw, dr;
    logic [17:0] maddr;

    // Auxiliary DUTs (WAIT_CYCLES 1 and 15) share one stimulus
    logic        x_req = 0, x_we = 0;
    logic [17:0] x_addr = 0;
    logic [15:0] x_wd = 0;
    logic        u1_agnt, u1_arv, u1_bgnt, u1_brv, u1_ce_n, u1_oe_n, u1_we_n, u1_rw;
    logic        u15_agnt, u15_arv, u15_bgnt, u15_brv, u15_ce_n, u15_oe_n, u15_we_n, u15_rw;
    logic [15:0] u1_rdata, u1_dw, u1_dr, u15_rdata, u15_dw, u15_dr;
    logic [17:0] u1_addr, u15_addr;

    sram_access_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wd),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rv),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wd),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rv),
        .rdata_o(rdata), .mem_addr_o(maddr), .mem_ce_n_o(ce_n), .mem_oe_n_o(oe_n),
        .mem_we_n_o(we_n), .rw_o(rw), .dw_o(dw), .dr_i(dr)
    );

    sram_access_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
        .clk_i(clk_i), .rst_ni(rst_n),
        .a_req_i(x_req), .a_we_i(x_we), .a_addr_i(x_addr), .a_wdata_i(x_wd),
        .a_gnt_o(u1_agnt), .a_rvalid_o(u1_arv),
        .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(18'h0), .b_wdata_i(16'h0),
        .b_gnt_o(u1_bgnt), .b_rvalid_o(u1_brv),
        .rdata_o(u1_rdata), .mem_addr_o(u1_addr), .mem_ce_n_o(u1_ce_n), .mem_oe_n_o(u1_oe_n),
        .mem_we_n_o(u1_we_n), .rw_o(u1_rw), .dw_o(u1_dw), .dr_i(u1_dr)
    );

    sram_access_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(15)) dut_w15 (
        .clk_i(clk_i), .rst_ni(rst_n),
        .a_req_i(x_req), .a_we_i(x_we), .a_addr_i(x_addr), .a_wdata_i(x_wd),
        .a_gnt_o(u15_agnt), .a_rvalid_o(u15_arv),
        .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(18'h0), .b_wdata_i(16'h0),
        .b_gnt_o(u15_bgnt), .b_rvalid_o(u15_brv),
        .rdata_o(u15_rdata), .mem_addr_o(u15_addr), .mem_ce_n_o(u15_ce_n),
        .mem_oe_n_o(u15_oe_n), .mem_we_n_o(u15_we_n), .rw_o(u15_rw), .dw_o(u15_dw),
        .dr_i(u15_dr)
    );

    // SRAM behind the separator for the main DUT; aux DUTs see a constant bus value
    logic [15:0] sram [256];
    assign dr     = !oe_n ? sram[maddr[7:0]] : 16'hdead;
    assign u1_dr  = !u1_oe_n ? 16'hA5C3 : 16'h0000;
    assign u15_dr = !u15_oe_n ? 16'hA5C3 : 16'h0000;
    always @(posedge clk_i) if (!we_n && !ce_n) sram[maddr[7:0]] <= dw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_inv(input string tag, input logic c_n, input logic o_n, input logic w_n,
                           input logic r);
        chk({tag, "_we_needs_rw_ce"}, (!w_n && !(r && !c_n)) ? 1'b1 : 1'b0, 1'b0);
        chk({tag, "_rw_oe_conflict"}, r && !o_n, 1'b0);
    endtask

    // Model: t = position in the current transaction (0 idle, 1 setup, 2..W+1 access, W+2 turn)
    int          t = 0;
    bit          m_own = 0, m_ptr = 0, m_we = 0;
    logic [17:0] m_addr = 0;
    logic [15:0] m_wd = 0, m_rdata = 0;
    logic [15:0] exp_mem [256];

    initial forever begin
        @(posedge clk_i or negedge rst_n);
        if (!rst_n) begin
            t = 0; m_ptr = 0; m_we = 0; m_addr = '0; m_rdata = '0;
        end else if (t == 0) begin
            if (a_req || b_req) begin
                m_own  = (a_req && b_req) ? m_ptr : !a_req;
                m_ptr  = !m_own;
                m_we   = m_own ? b_we : a_we;
                m_addr = m_own ? b_addr : a_addr;
                m_wd   = m_own ? b_wd : a_wd;
                t = 1;
            end
        end else if (t == W + 2) begin
            t = 0;
        end else begin
            t = t + 1;
            if (t == W + 2) begin
                if (m_we) exp_mem[m_addr[7:0]] = m_wd;
                else m_rdata = exp_mem[m_addr[7:0]];
            end
        end
    end

    initial begin : cmp
        bit bus;
        forever begin
            @(negedge clk_i);
            bus = (t >= 1) && (t <= W + 1);
            chk("ce_n", ce_n, !bus);
            chk("rw", rw, bus && m_we);
            chk("we_n", we_n, !(m_we && t >= 2 && t <= W + 1));
            chk("oe_n", oe_n, !(bus && !m_we));
            chk("a_gnt", a_gnt, t == 1 && !m_own);
            chk("b_gnt", b_gnt, t == 1 && m_own);
            chk("a_rvalid", a_rv, t == W + 2 && !m_we && !m_own);
            chk("b_rvalid", b_rv, t == W + 2 && !m_we && m_own);
            chk("rdata", rdata, m_rdata);
            if (t >= 1) chk("mem_addr", maddr, m_addr);
            if (bus && m_we) chk("dw", dw, m_wd);
            chk_inv("main", ce_n, oe_n, we_n, rw);
            chk_inv("w1", u1_ce_n, u1_oe_n, u1_we_n, u1_rw);
            chk_inv("w15", u15_ce_n, u15_oe_n, u15_we_n, u15_rw);
        end
    end

    // Running totals for width/count measurements
    int gnt_cnt = 0, w1_we = 0, w15_we = 0, w1_oe = 0, w15_oe = 0, w1_rv = 0, w15_rv = 0;
    initial forever begin
        @(negedge clk_i);
        gnt_cnt += int'(a_gnt) + int'(b_gnt);
        w1_we   += int'(!u1_we_n);
        w15_we  += int'(!u15_we_n);
        w1_oe   += int'(!u1_oe_n);
        w15_oe  += int'(!u15_oe_n);
        w1_rv   += int'(u1_arv);
        w15_rv  += int'(u15_arv);
    end

    task automatic do_req(input bit port, input bit we, input logic [17:0] addr,
                          input logic [15:0] wd, output int gcyc);
        @(negedge clk_i);
        if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wd = wd; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wd = wd; end
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (port ? b_gnt : a_gnt) begin
                gcyc = cyc;
                break;
            end
        end
        a_req = 0;
        b_req = 0;
        chk("gnt_seen", gcyc >= 0, 1'b1);
    endtask

    task automatic cap4(output logic [3:0] vrw, output logic [3:0] vwen,
                        output logic [3:0] voen, output logic [3:0] vrv,
                        output logic [3:0] vgnt, output logic [15:0] cdw,
                        output logic [15:0] crd);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            vrw[i] = rw; vwen[i] = we_n; voen[i] = oe_n;
            vrv[i] = a_rv | b_rv; vgnt[i] = a_gnt | b_gnt;
            if (i == 0) cdw = dw;
            if (i == 3) crd = rdata;
        end
    endtask

    initial begin : stim
        int g0, g1, n, base, b1, b2, b3, b4, b5, b6;
        int own [4];
        int gc [4];
        logic [3:0] v_rw, v_wen, v_oen, v_rv, v_gnt;
        logic [15:0] c_dw, c_rd;
        own = '{-1, -1, -1, -1};
        gc  = '{0, 0, 0, 0};

        repeat (3) @(negedge clk_i);
        chk("rst_mem_addr", maddr, 0);
        chk("rst_dw", dw, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_rw", rw, 0);
        rst_n = 1;

        // Reset in the middle of a write
        do_req(0, 1, 18'h30, 16'h7777, g0);
        n = 0;
        while (we_n !== 1'b0 && n < 10) begin @(negedge clk_i); n++; end
        chk("t1_we_low_before_reset", we_n, 0);
        #2 rst_n = 0;
        #1;
        chk("t1_we_n_released", we_n, 1);
        chk("t1_rw_released", rw, 0);
        chk("t1_ce_n_released", ce_n, 1);
        @(negedge clk_i);
        rst_n = 1;
        base = gnt_cnt;
        repeat (8) @(negedge clk_i);
        chk("t1_no_gnt_after_reset", gnt_cnt - base, 0);

        // Both requesters held: A,B,A,B one every W+3 cycles
        @(negedge clk_i);
        a_we = 1; b_we = 1; a_addr = 18'h40; b_addr = 18'h41; a_wd = 16'h4A4A; b_wd = 16'h4B4B;
        a_req = 1; b_req = 1;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk_i);
            if (a_gnt || b_gnt) begin
                chk("t4_single_gnt", a_gnt && b_gnt, 0);
                own[n] = int'(b_gnt);
                gc[n] = cyc;
                n++;
            end
        end
        a_req = 0; b_req = 0;
        chk("t4_grant_count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_owner%0d", i), own[i], i % 2);
        for (int i = 1; i < 4; i++) chk($sformatf("t4_gap%0d", i), gc[i] - gc[i-1], 5);
        repeat (5) @(negedge clk_i);

        // A write 0x1234 @0x10
        do_req(0, 1, 18'h10, 16'h1234, g0);
        cap4(v_rw, v_wen, v_oen, v_rv, v_gnt, c_dw, c_rd);
        chk("t2_rw_pattern", v_rw, 4'b0111);
        chk("t2_we_n_pattern", v_wen, 4'b1001);
        chk("t2_oe_n_pattern", v_oen, 4'b1111);
        chk("t2_gnt_pattern", v_gnt, 4'b0001);
        chk("t2_dw", c_dw, 16'h1234);

        // B read @0x10
        do_req(1, 0, 18'h10, 16'h0, g0);
        cap4(v_rw, v_wen, v_oen, v_rv, v_gnt, c_dw, c_rd);
        chk("t3_oe_n_pattern", v_oen, 4'b1000);
        chk("t3_rw_pattern", v_rw, 4'b0000);
        chk("t3_rvalid_pattern", v_rv, 4'b1000);
        chk("t3_rdata", c_rd, 16'h1234);

        // Write then immediate read of the same address
        do_req(0, 1, 18'h20, 16'hBEEF, g0);
        do_req(0, 0, 18'h20, 16'h0, g1);
        chk("t5_gap", g1 - g0, 5);
        n = 0;
        while (!a_rv && n < 10) begin @(negedge clk_i); n++; end
        chk("t5_rvalid_seen", a_rv, 1);
        chk("t5_rdata", rdata, 16'hBEEF);
        repeat (3) @(negedge clk_i);

        // Strobe widths for WAIT_CYCLES=1 and 15
        b1 = w1_we; b2 = w15_we;
        @(negedge clk_i);
        x_req = 1; x_we = 1; x_addr = 18'h5; x_wd = 16'h1111;
        @(negedge clk_i);
        x_req = 0;
        repeat (20) @(negedge clk_i);
        chk("t6_w1_we_width", w1_we - b1, 1);
        chk("t6_w15_we_width", w15_we - b2, 15);
        b3 = w1_oe; b4 = w15_oe; b5 = w1_rv; b6 = w15_rv;
        x_we = 0; x_req = 1;
        @(negedge clk_i);
        x_req = 0;
        repeat (20) @(negedge clk_i);
        chk("t6_w1_oe_width", w1_oe - b3, 2);
        chk("t6_w15_oe_width", w15_oe - b4, 16);
        chk("t6_w1_rvalid_count", w1_rv - b5, 1);
        chk("t6_w15_rvalid_count", w15_rv - b6, 1);
        chk("t6_w1_rdata", u1_rdata, 16'hA5C3);
        chk("t6_w15_rdata", u15_rdata, 16'hA5C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
